// File: rtl/lbus_word_target_pkg.sv
// Shared definitions for the local-bus word target: SIZ codes, FSM states
// and the byte-lane enable mapping.
package lbus_word_target_pkg;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  // Lane mask bit1 = UU (D[15:8]), bit0 = UM (D[7:0]).
  function automatic logic [1:0] lane_mask(input logic [1:0] siz, input logic a0);
    logic [1:0] mask;
    mask = 2'b11;
    if (siz == SIZ_BYTE) begin
      mask = a0 ? 2'b01 : 2'b10;
    end
    return mask;
  endfunction

endpackage

// File: rtl/lbus_target_regfile.sv
// Bank of 32-bit registers written one 16-bit word at a time through
// lane-masked UU/UM writes, with a combinational word read mux.
module lbus_target_regfile
  import lbus_word_target_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic                    wr_a1,
  input  logic [1:0]              wr_lanes,
  input  logic [15:0]             wr_data,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic                    rd_a1,
  output logic [15:0]             rd_data,
  output logic [32*NUM_REGS-1:0]  regs_flat
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [31:0] reg_q;
      logic [31:0] reg_d;
      logic        hit;

      assign hit = wr_en && (wr_idx == IDX_W'(gi));

      // A[1]=0 addresses the high word, A[1]=1 the low word.
      always_comb begin
        reg_d = reg_q;
        if (hit) begin
          if (!wr_a1) begin
            if (wr_lanes[1]) reg_d[31:24] = wr_data[15:8];
            if (wr_lanes[0]) reg_d[23:16] = wr_data[7:0];
          end else begin
            if (wr_lanes[1]) reg_d[15:8]  = wr_data[15:8];
            if (wr_lanes[0]) reg_d[7:0]   = wr_data[7:0];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs_flat[32*gi +: 32] = reg_q;
    end
  endgenerate

  // Indices with no backing register fall through to zero.
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_word = regs_flat[32*i +: 32];
      end
    end
    rd_data = rd_a1 ? rd_word[15:0] : rd_word[31:16];
  end

endmodule

// File: rtl/lbus_word_target.sv
// Word-port responder for the Amiga-side local bus: decodes TSn/CSn,
// inserts wait states, pulses TACKn for one clock and serves a register bank.
module lbus_word_target
  import lbus_word_target_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int NUM_REGS    = 4,
  parameter int IDX_W       = 2
) (
  input  logic                    CLK80,
  input  logic                    RESET,
  input  logic                    TSn,
  input  logic                    CSn,
  input  logic                    RnW,
  input  logic [1:0]              SIZ,
  input  logic [1:0]              A_AMIGA,
  input  logic [IDX_W-1:0]        REG_IDX,
  input  logic [15:0]             D_IN,
  output logic [15:0]             D_OUT,
  output logic                    D_OE,
  output logic                    TACKn,
  output logic                    PORTSIZE,
  output logic [32*NUM_REGS-1:0]  REGS,
  output logic [15:0]             CYCLE_CNT
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             rnw_q, rnw_d;
  logic [1:0]       siz_q, siz_d;
  logic [1:0]       a_q, a_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      dout_q, dout_d;
  logic [15:0]      cyc_q, cyc_d;
  logic             tack_n_q, tack_n_d;
  logic             portsize_q, portsize_d;
  logic             oe_q, oe_d;

  logic             wr_en;
  logic [1:0]       wr_lanes;
  logic [15:0]      rd_data;

  assign wr_lanes = lane_mask(siz_q, a_q[0]);

  // The read port looks at the live bus so D_OUT can be captured on the TSn edge.
  lbus_target_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk       (CLK80),
    .rst       (RESET),
    .wr_en     (wr_en),
    .wr_idx    (idx_q),
    .wr_a1     (a_q[1]),
    .wr_lanes  (wr_lanes),
    .wr_data   (D_IN),
    .rd_idx    (REG_IDX),
    .rd_a1     (A_AMIGA[1]),
    .rd_data   (rd_data),
    .regs_flat (REGS)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    siz_d   = siz_q;
    a_d     = a_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    cyc_d   = cyc_q;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!TSn && !CSn) begin
          rnw_d = RnW;
          siz_d = SIZ;
          a_d   = A_AMIGA;
          idx_d = REG_IDX;
          cnt_d = 4'(WAIT_STATES);
          if (RnW) begin
            dout_d = rd_data;
          end
          state_d = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        wr_en   = !rnw_q;
        cyc_d   = cyc_q + 16'd1;
        state_d = ST_RECOVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they leave the flops clean.
  always_comb begin
    tack_n_d   = (state_d != ST_ACK);
    portsize_d = (state_d == ST_WAIT) || (state_d == ST_ACK);
    oe_d       = portsize_d && rnw_d;
  end

  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rnw_q      <= 1'b0;
      siz_q      <= '0;
      a_q        <= '0;
      idx_q      <= '0;
      dout_q     <= '0;
      cyc_q      <= '0;
      tack_n_q   <= 1'b1;
      portsize_q <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rnw_q      <= rnw_d;
      siz_q      <= siz_d;
      a_q        <= a_d;
      idx_q      <= idx_d;
      dout_q     <= dout_d;
      cyc_q      <= cyc_d;
      tack_n_q   <= tack_n_d;
      portsize_q <= portsize_d;
      oe_q       <= oe_d;
    end
  end

  assign TACKn     = tack_n_q;
  assign PORTSIZE  = portsize_q;
  assign D_OE      = oe_q;
  assign D_OUT     = dout_q;
  assign CYCLE_CNT = cyc_q;

endmodule
